seg7_scan_decoder: RTL and testbench

Receive-side decoder for the multiplexed 4-digit seven-segment bus (active-low segments C[7:1], DP and anodes AN[3:0]). It samples the scanned bus and reconstructs the displayed BCD value and decimal-point position as a coherent 16-bit frame. It sits beside the display driver as an on-chip self-check and readback path, so step-count and distance values can be verified from the pins rather than the source counters.

---
 rtl/seg7_scan_decoder.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a scanned 4-digit active-low seven-segment bus.
// Rebuilds the displayed BCD value and decimal points as whole frames.
module seg7_scan_decoder #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 2_000_000
) (
   input  logic        clk100Mhz,
   input  logic        rst,
   input  logic [7:1]  C,
   input  logic        DP,
   input  logic [3:0]  AN,
   output logic [15:0] bcd,
   output logic [3:0]  dp_mask,
   output logic        frame_valid,
   output logic        alive,
   output logic        seg_err,
   output logic        an_err
);
   localparam int             WDW      = $clog2(TIMEOUT + 1);
   localparam logic [3:0]     SETTLE_C = 4'(SETTLE);
   localparam logic [WDW-1:0] TMO_LAST = WDW'(TIMEOUT - 1);
   localparam logic [WDW-1:0] TMO_SAT  = WDW'(TIMEOUT);

   // Bus packing: [11:8]=AN, [7:1]=C, [0]=DP
   logic [11:0]    sync1_q, sync2_q, prev_q;
   logic [3:0]     stab_q, stab_d;
   logic           captured_q, captured_d;
   logic [15:0]    shadow_q, shadow_d;
   logic [3:0]     shadow_dp_q, shadow_dp_d;
   logic [3:0]     mask_q, mask_d;
   logic [15:0]    bcd_q, bcd_d;
   logic [3:0]     dp_mask_q, dp_mask_d;
   logic           fv_q, fv_d;
   logic           alive_q, alive_d;
   logic           seg_err_q, seg_err_d;
   logic           an_err_q, an_err_d;
   logic [WDW-1:0] wd_q, wd_d;

   logic [3:0] an_low;
   logic [6:0] seg_s;
   logic       dp_on, changed, an_changed, settled, one_hot, multi_low;
   logic       capture, publish, expire;
   logic [4:0] dec;
   logic [3:0] slot_hit;

   // Returns {undecodable, nibble} for an active-high abcdefg pattern.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b1111110: decode = 5'h00;
         7'b0110000: decode = 5'h01;
         7'b1101101: decode = 5'h02;
         7'b1111001: decode = 5'h03;
         7'b0110011: decode = 5'h04;
         7'b1011011: decode = 5'h05;
         7'b1011111: decode = 5'h06;
         7'b1110000: decode = 5'h07;
         7'b1111111: decode = 5'h08;
         7'b1111011: decode = 5'h09;
         default:    decode = 5'h1F;
      endcase
   endfunction

   assign an_low     = ~sync2_q[11:8];
   assign seg_s      = ~sync2_q[7:1];
   assign dp_on      = ~sync2_q[0];
   assign changed    = (sync2_q != prev_q);
   assign an_changed = (sync2_q[11:8] != prev_q[11:8]);
   assign settled    = (stab_q == SETTLE_C) && !changed;
   assign one_hot    = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
   assign multi_low  = (an_low != 4'd0) && !one_hot;
   assign capture    = settled && one_hot && !captured_q;
   assign publish    = (mask_q == 4'hF);
   assign expire     = !capture && (wd_q == TMO_LAST);
   assign dec        = decode(seg_s);

   for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_hit[gi]           = capture & an_low[gi];
      assign shadow_d[4*gi +: 4]    = slot_hit[gi] ? dec[3:0] : shadow_q[4*gi +: 4];
      assign shadow_dp_d[gi]        = slot_hit[gi] ? dp_on : shadow_dp_q[gi];
   end

   always_comb begin
      stab_d     = stab_q;
      captured_d = captured_q;
      mask_d     = mask_q;
      bcd_d      = bcd_q;
      dp_mask_d  = dp_mask_q;
      fv_d       = 1'b0;
      alive_d    = alive_q;
      seg_err_d  = seg_err_q | (capture & dec[4]);
      an_err_d   = an_err_q | (settled & multi_low);
      wd_d       = wd_q;

      if (changed)
         stab_d = '0;
      else if (stab_q != SETTLE_C)
         stab_d = stab_q + 4'd1;

      // One capture per anode dwell; a new dwell begins when AN moves.
      captured_d = an_changed ? 1'b0 : (captured_q | capture);

      if (publish) begin
         bcd_d     = shadow_q;
         dp_mask_d = shadow_dp_q;
         fv_d      = 1'b1;
      end
      mask_d = ((publish || expire) ? 4'd0 : mask_q) | slot_hit;

      if (capture) begin
         wd_d    = '0;
         alive_d = 1'b1;
      end else begin
         if (wd_q != TMO_SAT)
            wd_d = wd_q + WDW'(1);
         if (expire)
            alive_d = 1'b0;
      end
   end

   always_ff @(posedge clk100Mhz or negedge rst) begin
      if (!rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         prev_q      <= '0;
         stab_q      <= '0;
         captured_q  <= 1'b0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         mask_q      <= '0;
         bcd_q       <= '0;
         dp_mask_q   <= '0;
         fv_q        <= 1'b0;
         alive_q     <= 1'b0;
         seg_err_q   <= 1'b0;
         an_err_q    <= 1'b0;
         wd_q        <= '0;
      end else begin
         sync1_q     <= {AN, C, DP};
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         stab_q      <= stab_d;
         captured_q  <= captured_d;
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
         mask_q      <= mask_d;
         bcd_q       <= bcd_d;
         dp_mask_q   <= dp_mask_d;
         fv_q        <= fv_d;
         alive_q     <= alive_d;
         seg_err_q   <= seg_err_d;
         an_err_q    <= an_err_d;
         wd_q        <= wd_d;
      end
   end

   assign bcd         = bcd_q;
   assign dp_mask     = dp_mask_q;
   assign frame_valid = fv_q;
   assign alive       = alive_q;
   assign seg_err     = seg_err_q;
   assign an_err      = an_err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: scripted scenarios plus a
// randomized scan compared against a slot/mask frame model.
module tb_seg7_scan_decoder;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:1]  c_r = 7'h7F;
   logic        dp_r = 1'b1;
   logic [3:0]  an_r = 4'hF;
   logic [15:0] bcd;
   logic [3:0]  dp_mask;
   logic        frame_valid, alive, seg_err, an_err;

   int checks = 0;
   int passed = 0;
   int fv_count = 0;

   // Active-high abcdefg per digit
   logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011};

   int m_dig [4];
   bit m_dpb [4];
   bit m_mask [4];

   always #5 clk = ~clk;
   always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

   seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk100Mhz(clk), .rst(rst), .C(c_r), .DP(dp_r), .AN(an_r),
      .bcd(bcd), .dp_mask(dp_mask), .frame_valid(frame_valid),
      .alive(alive), .seg_err(seg_err), .an_err(an_err));

   task automatic drive(input logic [3:0] an, input logic [7:1] c, input logic dp, input int n);
      an_r = an; c_r = c; dp_r = dp;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input int slot, input int digit, input bit dp_on, input int n);
      logic [3:0] an;
      logic [6:0] pat;
      an = ~(4'b0001 << slot);
      pat = seg_tab[digit];
      drive(an, ~pat, ~dp_on, n);
   endtask

   task automatic blank(input int n);
      drive(4'hF, 7'h7F, 1'b1, n);
   endtask

   task automatic check_all_zero(input string tag);
      checks++; if (bcd !== 16'h0) $display("FAIL %s_bcd: got %h expected 0000", tag, bcd); else passed++;
      checks++; if (dp_mask !== 4'h0) $display("FAIL %s_dp_mask: got %b expected 0000", tag, dp_mask); else passed++;
      checks++; if (frame_valid !== 1'b0) $display("FAIL %s_frame_valid: got %b expected 0", tag, frame_valid); else passed++;
      checks++; if (alive !== 1'b0) $display("FAIL %s_alive: got %b expected 0", tag, alive); else passed++;
      checks++; if (seg_err !== 1'b0) $display("FAIL %s_seg_err: got %b expected 0", tag, seg_err); else passed++;
      checks++; if (an_err !== 1'b0) $display("FAIL %s_an_err: got %b expected 0", tag, an_err); else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      blank(3);
      $display("test_reset done");
   endtask

   task automatic test_scan_1234();
      int base;
      base = fv_count;
      show(3, 1, 0, 20); show(2, 2, 0, 20); show(1, 3, 1, 20); show(0, 4, 0, 20);
      blank(3);
      checks++; if (bcd !== 16'h1234) $display("FAIL scan_bcd: got %h expected 1234", bcd); else passed++;
      checks++; if (dp_mask !== 4'b0010) $display("FAIL scan_dp_mask: got %b expected 0010", dp_mask); else passed++;
      checks++; if (fv_count - base !== 1) $display("FAIL scan_frames: got %0d expected 1", fv_count - base); else passed++;
      checks++; if (seg_err !== 1'b0) $display("FAIL scan_seg_err: got %b expected 0", seg_err); else passed++;
      checks++; if (alive !== 1'b1) $display("FAIL scan_alive: got %b expected 1", alive); else passed++;
      $display("test_scan_1234 bcd=%h dp_mask=%b", bcd, dp_mask);
   endtask

   task automatic test_glitch();
      int base;
      logic [6:0] p8, p1;
      base = fv_count;
      p8 = seg_tab[8]; p1 = seg_tab[1];
      show(3, 0, 0, 20);
      drive(4'b1011, ~p8, 1'b1, 1);
      drive(4'b1011, ~p1, 1'b1, 1);
      drive(4'b1011, ~p8, 1'b1, 1);
      show(2, 7, 0, 20);
      show(1, 5, 0, 20); show(0, 6, 0, 20);
      blank(3);
      checks++; if (bcd !== 16'h0756) $display("FAIL glitch_bcd: got %h expected 0756", bcd); else passed++;
      checks++; if (fv_count - base !== 1) $display("FAIL glitch_frames: got %0d expected 1", fv_count - base); else passed++;
      checks++; if (seg_err !== 1'b0) $display("FAIL glitch_seg_err: got %b expected 0", seg_err); else passed++;
      $display("test_glitch bcd=%h", bcd);
   endtask

   task automatic test_an_err();
      int base;
      logic [6:0] p3;
      base = fv_count;
      p3 = seg_tab[3];
      checks++; if (an_err !== 1'b0) $display("FAIL an_err_before: got %b expected 0", an_err); else passed++;
      drive(4'b1100, ~p3, 1'b1, 10);
      checks++; if (an_err !== 1'b1) $display("FAIL an_err_set: got %b expected 1", an_err); else passed++;
      checks++; if (bcd !== 16'h0756) $display("FAIL an_err_bcd: got %h expected 0756", bcd); else passed++;
      blank(5);
      checks++; if (fv_count - base !== 0) $display("FAIL an_err_frames: got %0d expected 0", fv_count - base); else passed++;
      $display("test_an_err an_err=%b", an_err);
   endtask

   task automatic test_seg_err();
      int base;
      base = fv_count;
      show(3, 0, 0, 20);
      drive(4'b1011, ~7'b0000001, 1'b1, 20);
      show(1, 0, 0, 20); show(0, 0, 0, 20);
      blank(3);
      checks++; if (bcd !== 16'h0F00) $display("FAIL seg_bcd: got %h expected 0F00", bcd); else passed++;
      checks++; if (seg_err !== 1'b1) $display("FAIL seg_err_set: got %b expected 1", seg_err); else passed++;
      show(3, 1, 0, 20); show(2, 1, 0, 20); show(1, 1, 0, 20); show(0, 1, 0, 20);
      blank(3);
      checks++; if (bcd !== 16'h1111) $display("FAIL seg_bcd2: got %h expected 1111", bcd); else passed++;
      checks++; if (seg_err !== 1'b1) $display("FAIL seg_err_sticky: got %b expected 1", seg_err); else passed++;
      checks++; if (fv_count - base !== 2) $display("FAIL seg_frames: got %0d expected 2", fv_count - base); else passed++;
      $display("test_seg_err seg_err=%b bcd=%h", seg_err, bcd);
   endtask

   task automatic test_timeout();
      int base;
      base = fv_count;
      show(3, 5, 0, 20); show(2, 6, 0, 20); show(1, 7, 0, 20); show(0, 8, 0, 20);
      blank(75);
      checks++; if (alive !== 1'b1) $display("FAIL tmo_alive_early: got %b expected 1", alive); else passed++;
      blank(25);
      checks++; if (alive !== 1'b0) $display("FAIL tmo_alive_drop: got %b expected 0", alive); else passed++;
      checks++; if (bcd !== 16'h5678) $display("FAIL tmo_bcd_hold: got %h expected 5678", bcd); else passed++;
      // Partial frame across an expiry must be discarded
      show(3, 1, 0, 20);
      checks++; if (alive !== 1'b1) $display("FAIL tmo_alive_resume: got %b expected 1", alive); else passed++;
      show(2, 2, 0, 20);
      blank(120);
      checks++; if (alive !== 1'b0) $display("FAIL tmo_alive_drop2: got %b expected 0", alive); else passed++;
      show(1, 3, 0, 20); show(0, 4, 0, 20);
      blank(5);
      checks++; if (fv_count - base !== 1) $display("FAIL tmo_partial_frames: got %0d expected 1", fv_count - base); else passed++;
      show(3, 9, 0, 20); show(2, 1, 1, 20);
      blank(3);
      checks++; if (bcd !== 16'h9134) $display("FAIL tmo_new_bcd: got %h expected 9134", bcd); else passed++;
      checks++; if (dp_mask !== 4'b0100) $display("FAIL tmo_new_dp: got %b expected 0100", dp_mask); else passed++;
      checks++; if (fv_count - base !== 2) $display("FAIL tmo_new_frames: got %0d expected 2", fv_count - base); else passed++;
      $display("test_timeout bcd=%h alive=%b", bcd, alive);
   endtask

   task automatic test_reset_mid();
      int base;
      show(3, 2, 0, 20); show(2, 3, 0, 20);
      #2 rst = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      base = fv_count;
      show(1, 7, 0, 20); show(0, 6, 0, 20);
      blank(3);
      checks++; if (fv_count - base !== 0) $display("FAIL midreset_partial: got %0d expected 0", fv_count - base); else passed++;
      checks++; if (bcd !== 16'h0) $display("FAIL midreset_bcd_hold: got %h expected 0000", bcd); else passed++;
      show(3, 9, 0, 20); show(2, 8, 0, 20);
      blank(3);
      checks++; if (bcd !== 16'h9876) $display("FAIL midreset_bcd: got %h expected 9876", bcd); else passed++;
      checks++; if (fv_count - base !== 1) $display("FAIL midreset_frames: got %0d expected 1", fv_count - base); else passed++;
      $display("test_reset_mid bcd=%h", bcd);
   endtask

   task automatic test_random();
      int base, frames, slot, digit, n, prev_slot;
      bit dpb, full;
      logic [15:0] exp_bcd;
      logic [3:0]  exp_dp;
      base = fv_count;
      frames = 0;
      prev_slot = 0;
      exp_bcd = 16'h9876;
      exp_dp = 4'h0;
      for (int i = 0; i < 4; i++) m_mask[i] = 1'b0;
      for (int k = 0; k < 40; k++) begin
         slot  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : (prev_slot + 3) % 4;
         digit = $urandom_range(9, 0);
         dpb   = 1'($urandom_range(1, 0));
         n     = $urandom_range(30, 12);
         if (k == 0 || slot == prev_slot || $urandom_range(1, 0) == 1)
            blank($urandom_range(3, 1));
         show(slot, digit, dpb, n);
         prev_slot = slot;
         m_dig[slot] = digit; m_dpb[slot] = dpb; m_mask[slot] = 1'b1;
         full = m_mask[0] & m_mask[1] & m_mask[2] & m_mask[3];
         if (full) begin
            for (int i = 0; i < 4; i++) begin
               exp_bcd[4*i +: 4] = 4'(m_dig[i]);
               exp_dp[i] = m_dpb[i];
               m_mask[i] = 1'b0;
            end
            frames++;
         end
         checks++; if (fv_count - base !== frames) $display("FAIL rand_frames[%0d]: got %0d expected %0d", k, fv_count - base, frames); else passed++;
         checks++; if (bcd !== exp_bcd) $display("FAIL rand_bcd[%0d]: got %h expected %h", k, bcd, exp_bcd); else passed++;
         checks++; if (dp_mask !== exp_dp) $display("FAIL rand_dp[%0d]: got %b expected %b", k, dp_mask, exp_dp); else passed++;
         $display("rand %0d slot=%0d digit=%0d dp=%0d bcd=%h frames=%0d", k, slot, digit, dpb, bcd, frames);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_scan_1234();
      test_glitch();
      test_an_err();
      test_seg_err();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
